// File: rtl/fabric_cfg_pkg.sv
// rtl/fabric_cfg_pkg.sv - shared configuration header fields and sequencer state encoding
package fabric_cfg_pkg;

  // Header word layout: [31:28] magic, [27:20] column, [19:5] unused, [4:0] frame index
  localparam logic [3:0] CFG_MAGIC = 4'hA;
  localparam int MAGIC_LSB = 28;
  localparam int MAGIC_W   = 4;
  localparam int COL_LSB   = 20;
  localparam int COL_W     = 8;
  localparam int FRAME_LSB = 0;
  localparam int FRAME_W   = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } cfg_state_e;

  typedef struct packed {
    logic [MAGIC_W-1:0] magic;
    logic [COL_W-1:0]   column;
    logic [FRAME_W-1:0] frame;
  } cfg_header_t;

  function automatic cfg_header_t parse_header(input logic [31:0] w);
    cfg_header_t h;
    h.magic  = w[MAGIC_LSB +: MAGIC_W];
    h.column = w[COL_LSB +: COL_W];
    h.frame  = w[FRAME_LSB +: FRAME_W];
    return h;
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - registered one-hot decoder of (column, frame) into the FrameStrobe vector
module frame_strobe_decoder
  import fabric_cfg_pkg::*;
#(
  parameter int NumberOfColumns = 10,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [COL_W-1:0]                           column,
  input  logic [FRAME_W-1:0]                         frame,
  input  logic                                       enable,
  output logic [NumberOfColumns*MaxFramesPerCol-1:0] strobe
);

  localparam int NSTB = NumberOfColumns * MaxFramesPerCol;

  logic [NSTB-1:0] strobe_d;
  logic [NSTB-1:0] strobe_q;

  // Only in-range (column, frame) pairs can ever set a bit, so the output is at most one-hot
  always_comb begin
    strobe_d = '0;
    for (int c = 0; c < NumberOfColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        if (enable && (column == COL_W'(c)) && (frame == FRAME_W'(f))) begin
          strobe_d[c*MaxFramesPerCol + f] = 1'b1;
        end
      end
    end
  end

  // Registered so the strobe lines into the fabric never glitch; reset drops them at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/frame_write_sequencer.sv
// rtl/frame_write_sequencer.sv - assembles per-row frame words from a word stream and strobes one frame latch
module frame_write_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfRows    = 16,
  parameter int NumberOfColumns = 10,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1
) (
  input  logic                                       CLK,
  input  logic                                       RESET,
  input  logic [31:0]                                s_data,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumberOfColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                       busy,
  output logic                                       error,
  output logic [15:0]                                frames_written
);

  localparam int ROW_W   = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int MAX_CYC = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int FD_W    = NumberOfRows * FrameBitsPerRow;

  cfg_state_e         state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   column_q, column_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               skip_q, skip_d;
  logic               error_q, error_d;
  logic [15:0]        frames_written_q, frames_written_d;
  logic [FD_W-1:0]    frame_data_q, frame_data_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               strobe_en;
  logic               hs;
  cfg_header_t        hdr;

  // Next-state logic; registered outputs are derived from the next state so they line up with it
  always_comb begin
    state_d          = state_q;
    row_d            = row_q;
    cnt_d            = cnt_q;
    column_d         = column_q;
    frame_d          = frame_q;
    skip_d           = skip_q;
    error_d          = error_q;
    frames_written_d = frames_written_q;
    frame_data_d     = frame_data_q;
    hs               = s_valid && s_ready_q;
    hdr              = parse_header(s_data);

    case (state_q)
      IDLE: begin
        if (hs) begin
          if (hdr.magic != CFG_MAGIC) begin
            error_d = 1'b1;
          end else begin
            column_d = hdr.column;
            frame_d  = hdr.frame;
            // Out-of-range targets still consume their data words but never strobe
            skip_d   = (int'(hdr.column) >= NumberOfColumns) ||
                       (int'(hdr.frame) >= MaxFramesPerCol);
            if ((int'(hdr.column) >= NumberOfColumns) ||
                (int'(hdr.frame) >= MaxFramesPerCol)) begin
              error_d = 1'b1;
            end
            row_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          frame_data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data[FrameBitsPerRow-1:0];
          if (int'(row_q) == NumberOfRows - 1) begin
            row_d   = '0;
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      SETUP: begin
        if (int'(cnt_q) == SetupCycles - 1) begin
          cnt_d   = '0;
          state_d = skip_q ? HOLD : STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if (int'(cnt_q) == StrobeCycles - 1) begin
          cnt_d            = '0;
          frames_written_d = frames_written_q + 16'd1;
          state_d          = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d    = (state_d != IDLE);
    strobe_en = (state_d == STROBE);
  end

  // All sequencer state; reset aborts any frame in flight immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= IDLE;
      row_q            <= '0;
      cnt_q            <= '0;
      column_q         <= '0;
      frame_q          <= '0;
      skip_q           <= 1'b0;
      error_q          <= 1'b0;
      frames_written_q <= '0;
      frame_data_q     <= '0;
      s_ready_q        <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      row_q            <= row_d;
      cnt_q            <= cnt_d;
      column_q         <= column_d;
      frame_q          <= frame_d;
      skip_q           <= skip_d;
      error_q          <= error_d;
      frames_written_q <= frames_written_d;
      frame_data_q     <= frame_data_d;
      s_ready_q        <= s_ready_d;
      busy_q           <= busy_d;
    end
  end

  frame_strobe_decoder #(
    .NumberOfColumns(NumberOfColumns),
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_strobe_dec (
    .clk    (CLK),
    .rst    (RESET),
    .column (column_q),
    .frame  (frame_q),
    .enable (strobe_en),
    .strobe (FrameStrobe)
  );

  assign s_ready        = s_ready_q;
  assign busy           = busy_q;
  assign error          = error_q;
  assign frames_written = frames_written_q;
  assign FrameData      = frame_data_q;

endmodule

// File: doc/frame_write_sequencer.md
Name: frame_write_sequencer

Overview:
- Upstream feeder of every tile configuration memory in the fabric.
- Accepts a stream of 32-bit configuration words over a valid/ready handshake.
- For each frame, assembles one word per fabric row on the shared per-row FrameData bus, then pulses exactly one FrameStrobe bit, in the addressed column, to latch that frame.
- Sits between the bitstream source (UART/JTAG/host word port) and the fabric's FrameData/FrameStrobe distribution.

Parameters:
- FrameBitsPerRow, 32, width of one row's frame data word.
- MaxFramesPerCol, 20, number of frame strobes per column.
- NumberOfRows, 16, number of fabric rows, which is also the number of data words per frame.
- NumberOfColumns, 10, number of fabric columns.
- SetupCycles, 1, cycles FrameData is stable before the strobe rises (≥1).
- StrobeCycles, 1, strobe high time in cycles (≥1).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  reset; asynchronous, active-high.
- s_data  input  32  configuration word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid && s_ready.
- FrameData  output  NumberOfRows*FrameBitsPerRow  row r occupies bits [r*FBPR +: FBPR].
- FrameStrobe  output  NumberOfColumns*MaxFramesPerCol  column c occupies bits [c*MFPC +: MFPC].
- busy  output  1  high in any state other than IDLE.
- error  output  1  sticky protocol error flag.
- frames_written  output  16  count of strobed frames; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, active-high): FrameData=0, FrameStrobe=0, s_ready=0 during reset, busy=0, error=0, frames_written=0, state=IDLE, row counter=0.
  - Assertion mid-frame aborts immediately; no partial strobe survives.
  - s_ready goes 1 on the first clock after release.
- Header word: [31:28]=4'hA (magic), [27:20]=column, [19:5] ignored, [4:0]=frame index.
- States:
  - IDLE: s_ready=1. On handshake:
    - If magic≠A: set error, stay in IDLE, word dropped.
    - Otherwise latch column and frame, set a skip flag if column≥NumberOfColumns or frame≥MaxFramesPerCol (skip also sets error), row counter=0, go to LOAD.
  - LOAD: s_ready=1. Each handshake writes s_data into the row register selected by the row counter (row 0 first) and increments the counter. The handshake that writes row NumberOfRows-1 moves to SETUP with counter=0.
  - SETUP: s_ready=0, strobe low, lasts SetupCycles. Then:
    - If skip: go to HOLD.
    - Otherwise: go to STROBE.
  - STROBE: s_ready=0. FrameStrobe bit [column*MFPC+frame]=1, all others 0, for exactly StrobeCycles cycles. On the last cycle frames_written increments by 1. Go to HOLD.
  - HOLD: s_ready=0, strobe low, 1 cycle; FrameData unchanged. Go to IDLE.
- FrameStrobe is registered, glitch-free, and never has more than one bit set.
- FrameData changes only on LOAD handshakes and is held across SETUP/STROBE/HOLD and IDLE.
- Minimum frame period = 1 + NumberOfRows + SetupCycles + StrobeCycles + 1 cycles.
- s_valid without s_ready: no state change. s_data is don't-care when s_valid=0.
- error clears only on reset.
- A header or data word arriving during SETUP/STROBE/HOLD is back-pressured, not lost.
- frames_written wraps from 0xFFFF to 0x0000.

Decomposition:
- Shared package fabric_cfg_pkg:
  - header field constants: CFG_MAGIC=4'hA and bit positions of magic, column and frame;
  - state enum IDLE/LOAD/SETUP/STROBE/HOLD.
- One natural sub-module: frame_strobe_decoder, a registered one-hot decoder of (column, frame, enable) into the FrameStrobe vector.

Test Plan:
- Header 0xA030_0005 then 16 data words 0x1000_0000+r with s_valid held high -> FrameData row r = 0x1000_0000+r; after SetupCycles, FrameStrobe bit 3*20+5=65 is high for 1 cycle, all other bits 0; frames_written=1; total 20 cycles header to IDLE.
- Header with magic 0x5 -> error=1, s_ready stays 1, state IDLE, no strobe. The next valid header proceeds normally.
- Header column=10 (0xA0A0_0000) + 16 words -> error=1, data loaded, no strobe bit ever set, frames_written unchanged, returns to IDLE.
- Random s_valid gaps in LOAD, plus s_valid held high during SETUP/STROBE/HOLD -> no words lost or duplicated, s_ready=0 in those states, next frame correct.
- RESET asserted asynchronously during STROBE -> FrameStrobe=0 and FrameData=0 without waiting for a clock edge; after release a full frame completes correctly.
- StrobeCycles=3, SetupCycles=2 build; 0x10000 frames (or counter forced near 0xFFFF) -> strobe width 3, setup 2, and frames_written wraps to 0.
